fifo_ctrl: RTL
==============

Name: fifo_ctrl

Overview:
Single-clock FIFO controller that owns pointer and flag logic for the team's FIFO storage array. It accepts write/read requests, generates wrPtr/rdPtr and the memory write/read strobes, and tracks occupancy. It reports full/empty, almost-full/almost-empty and sticky error flags. It sits between producer/consumer logic and the RAM: the control side that drives the array's pointer and enable inputs.

Parameters:
N, 8, pointer width in bits
DEPTH, 90 (8'b0101_1010), number of entries; legal range 2..2^N; not necessarily a power of two
AF_MARGIN, 4, almost_full asserts when count >= DEPTH-AF_MARGIN
AE_MARGIN, 4, almost_empty asserts when count <= AE_MARGIN

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
wr_req  input  1  producer requests a write this cycle
rd_req  input  1  consumer requests a read this cycle
wrPtr  output  N  write address to RAM
rdPtr  output  N  read address to RAM
wr_en  output  1  RAM write strobe (accepted write)
rd_en  output  1  RAM read strobe (accepted read)
rd_valid  output  1  RAM rd_data valid this cycle
count  output  N+1  current occupancy 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  see AF_MARGIN
almost_empty  output  1  see AE_MARGIN
overflow  output  1  sticky: write requested while full
underflow  output  1  sticky: read requested while empty

Behaviour:
- Reset (rst=1 at posedge): wrPtr=0, rdPtr=0, count=0, rd_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0. wr_en/rd_en are 0 while rst=1.
- Accept: wr_acc = wr_req & ~full; rd_acc = rd_req & ~empty. Flags are those at the start of the cycle, i.e. from registered count.
- wr_en = wr_acc, rd_en = rd_acc. Both are combinational, same cycle as the request, so the RAM captures on the same edge.
- Pointer advance on accept: if ptr == DEPTH-1 then 0, else ptr+1. A non-accepted request leaves the pointer unchanged.
- count: +1 for write-only, -1 for read-only, unchanged for both or neither. It never exceeds DEPTH and never goes below 0.
- full/empty/almost_* decode combinationally from registered count. They reflect an accepted operation one cycle after its edge.
- rd_valid: registered rd_acc. Asserted the cycle after an accepted read, aligned with the RAM's 1-cycle registered read data.
- Simultaneous at empty: the write is accepted and the read is rejected (no fall-through). Count becomes 1 and underflow is set.
- Simultaneous at full: the read is accepted and the write is rejected. Count becomes DEPTH-1 and overflow is set.
- Simultaneous otherwise: both are accepted, count is unchanged, and both pointers advance.
- overflow: set on wr_req & full; underflow: set on rd_req & empty. Both hold until rst.
- Reset mid-operation: all state returns to reset values at the next edge, regardless of requests. RAM contents are not cleared and are treated as invalid.
- No combinational path from wr_req to rd_en or from rd_req to wr_en.

Decomposition:
- Shared package fifo_pkg holds the default constants FIFO_PTR_W=8, FIFO_DEPTH=90, FIFO_AF_MARGIN=4, FIFO_AE_MARGIN=4, so the controller, storage and wrappers agree.
- One natural sub-module, fifo_ptr_wrap: an N-bit modulo-DEPTH counter with inc and sync rst, instantiated twice (write and read pointer).
- The FIFO top wrapper pairing this block with the storage array is a separate block and not in scope.

Test Plan:
- Fill: rst, then 90 consecutive wr_req. Required:
  - almost_full rises after the 86th write.
  - full=1, count=90, wrPtr=0 (wrapped) after the 90th.
  - A 91st wr_req gives wr_en=0, wrPtr stays 0, overflow=1.
- Drain: from full, 90 consecutive rd_req. Required:
  - rd_en each cycle, rd_valid one cycle later.
  - almost_empty at count=4.
  - empty=1, rdPtr=0 at the end.
  - An extra rd_req gives rd_en=0 and underflow=1.
- Empty collision: count=0, wr_req=rd_req=1 for one cycle. Required: wr_en=1, rd_en=0, then count=1, wrPtr=1, rdPtr=0, underflow=1.
- Full collision: count=90, wr_req=rd_req=1. Required: rd_en=1, wr_en=0, then count=89, full=0, overflow=1.
- Steady-state/wrap: count=45, wrPtr=89, rdPtr=44, both requests for 3 cycles. Required: count stays 45, wrPtr 89->0->1->2, rdPtr 44->47.
- Reset mid-op: count=37, overflow=1, rst high for one cycle with wr_req=1. Required: next cycle count=0, pointers 0, overflow=0, empty=1, wr_en=0 during reset.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO constants so the controller, storage array and wrappers agree
// on pointer width, depth and flag margins.
package fifo_pkg;

    localparam int FIFO_PTR_W     = 8;
    localparam int FIFO_DEPTH     = 90;
    localparam int FIFO_AF_MARGIN = 4;
    localparam int FIFO_AE_MARGIN = 4;

endpackage

// File: rtl/fifo_ptr_wrap.sv
// N-bit modulo-DEPTH pointer: advances by one on inc and wraps from
// DEPTH-1 back to 0, so non-power-of-two depths address the array exactly.
module fifo_ptr_wrap
    import fifo_pkg::*;
#(
    parameter int N     = FIFO_PTR_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [N-1:0] ptr
);

    localparam logic [N-1:0] LAST = N'(DEPTH - 1);

    // Pointer register with synchronous reset and wrap at the last entry
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            if (ptr == LAST) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller: accepts write/read requests, drives the RAM
// pointers and strobes, tracks occupancy and reports level and error flags.
// Flags are decoded from the registered count, so an operation shows up in
// the flags one cycle after its edge and a request never falls through.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int N         = FIFO_PTR_W,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int AF_MARGIN = FIFO_AF_MARGIN,
    parameter int AE_MARGIN = FIFO_AE_MARGIN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_req,
    input  logic         rd_req,
    output logic [N-1:0] wrPtr,
    output logic [N-1:0] rdPtr,
    output logic         wr_en,
    output logic         rd_en,
    output logic         rd_valid,
    output logic [N:0]   count,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [N:0] DEPTH_C = (N+1)'(DEPTH);
    localparam logic [N:0] AF_TH   = (N+1)'(DEPTH - AF_MARGIN);
    localparam logic [N:0] AE_TH   = (N+1)'(AE_MARGIN);

    logic wr_acc;
    logic rd_acc;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_TH);
    assign almost_empty = (count <= AE_TH);

    // Each side is gated only by its own flag, so wr_req never reaches rd_en
    // and rd_req never reaches wr_en; strobes are held low during reset.
    assign wr_acc = wr_req & ~full  & ~rst;
    assign rd_acc = rd_req & ~empty & ~rst;
    assign wr_en  = wr_acc;
    assign rd_en  = rd_acc;

    fifo_ptr_wrap #(.N(N), .DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc),
        .ptr (wrPtr)
    );

    fifo_ptr_wrap #(.N(N), .DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc),
        .ptr (rdPtr)
    );

    // Occupancy, read-data valid pipeline and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            rd_valid <= rd_acc;
            if (wr_req && full) begin
                overflow <= 1'b1;
            end
            if (rd_req && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
